// File: rtl/cp_pipe_ctrl.sv
// cp_pipe_ctrl: sequences capture (c) and pass (p) phases for a chain of
// c/p-controlled latch stages, each cycling EMPTY -> FULL -> DRAIN -> EMPTY.
module cp_pipe_ctrl #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned OCC_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [STAGES-1:0] c,
  output logic [STAGES-1:0] p,
  output logic [OCC_W-1:0]  occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } stage_e;

  stage_e            state_q [STAGES];
  stage_e            state_d [STAGES];
  logic [STAGES-1:0] take;
  logic [STAGES-1:0] leave;
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] p_d;
  logic [OCC_W-1:0]  occ_d;

  assign in_ready  = (state_q[0] == EMPTY) && !flush && !rst;
  assign out_valid = (state_q[STAGES-1] == FULL);

  // A stage hands its item over on the same edge its successor captures it.
  always_comb begin
    take  = '0;
    leave = '0;
    take[0] = in_valid && in_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      take[i] = (state_q[i] == EMPTY) && (state_q[i-1] == FULL);
    end
    for (int unsigned i = 0; i + 1 < STAGES; i++) begin
      leave[i] = take[i+1];
    end
    leave[STAGES-1] = out_valid && out_ready;
  end

  // Per-stage next state; c toggles on capture, p toggles on DRAIN exit.
  always_comb begin
    state_d = state_q;
    c_d     = c;
    p_d     = p;
    if (flush) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        state_d[i] = EMPTY;
      end
      p_d = c;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        case (state_q[i])
          EMPTY: begin
            if (take[i]) begin
              state_d[i] = FULL;
              c_d[i]     = ~c[i];
            end
          end
          FULL: begin
            if (leave[i]) begin
              state_d[i] = DRAIN;
            end
          end
          DRAIN: begin
            state_d[i] = EMPTY;
            p_d[i]     = ~p[i];
          end
          default: state_d[i] = EMPTY;
        endcase
      end
    end
  end

  // Occupancy counts FULL stages only; DRAIN stages no longer own an item.
  always_comb begin
    occ_d = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (state_d[i] == FULL) begin
        occ_d = occ_d + OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        state_q[i] <= EMPTY;
      end
      c         <= '0;
      p         <= '0;
      occupancy <= '0;
    end else begin
      state_q   <= state_d;
      c         <= c_d;
      p         <= p_d;
      occupancy <= occ_d;
    end
  end

endmodule
